mvt_out_serializer: RTL and testbench
=====================================

// Module: mvt_out_serializer
// PURPOSE
//  Downstream sink of the mvt kernel's two ap_fifo outputs (x1_out, x2_out). Buffers each stream,
//  round-robin arbitrates, and serialises every word as a tagged nibble frame onto the 4-bit
//  data_out/data_valid pins of the board wrapper; probe_out flags lost data.
// PARAMETERS
//  DATA_W            32  kernel word width; multiple of 4
//  FIFO_DEPTH        4   entries per input buffer; power of 2, >=2
//  WORDS_PER_STREAM  40  words expected per stream per run (checksum trigger)
// PORTS
//  ap_clk         in   1       single clock
//  ap_rst         in   1       synchronous, active-high reset
//  x1_out_din     in   DATA_W  x1 word from kernel
//  x1_out_write   in   1       x1 write strobe
//  x1_out_full_n  out  1       x1 buffer not full
//  x2_out_din     in   DATA_W  x2 word from kernel
//  x2_out_write   in   1       x2 write strobe
//  x2_out_full_n  out  1       x2 buffer not full
//  data_out       out  4       serial nibble
//  data_valid     out  1       data_out carries frame nibble this cycle
//  probe_out      out  1       sticky overflow flag
// BEHAVIOUR
//  Reset (sampled on ap_clk edge): buffers empty, full_n=1, data_out=0, data_valid=0, probe_out=0,
//   FSM=IDLE, RR pointer=x1, word counters=0.
//  Write: accepted on edge where write=1 and full_n=1; write with full_n=0 dropped, probe_out<=1
//   (sticky until reset). Simultaneous write+pop on full buffer: pop frees slot only next cycle
//   (full_n combinational from registered count; no same-cycle pass-through).
//  Frame: 1 tag nibble (x1=4'h1, x2=4'h2) then DATA_W/4 nibbles MSB-first; data_valid=1 on all
//   1+DATA_W/4 cycles, back-to-back frames with no gap; data_out=0 whenever data_valid=0.
//  FSM: IDLE -> TAG when any buffer non-empty (pop selected word into shift reg same edge);
//   TAG -> DATA; DATA counts nibbles 0..DATA_W/4-1; last nibble -> TAG if a buffer non-empty
//   else IDLE. Latency: write edge to first tag nibble = 2 cycles when idle.
//  Arbitration: round-robin; if both non-empty, serve stream not served last; if one, serve it.
//  Word counters per stream saturate at WORDS_PER_STREAM.
//  Reset mid-frame: frame abandoned, buffered words discarded, outputs to reset values next cycle.
// CONFIGURATION
//  `MVT_OUT_CKSUM_EN defined: running XOR per stream of accepted words; once both counters reach
//   WORDS_PER_STREAM and buffers drained, FSM emits CK_TAG (4'hC) + DATA_W/4 nibbles of
//   x1_xor^x2_xor, then counters/XORs clear and next run begins. Undefined: no checksum states,
//   counters unused (may be optimised away); tag 4'hC never appears.
// STRUCTURE
//  Package mvt_out_pkg: TAG_X1/TAG_X2/TAG_CK constants, state enum (IDLE,TAG,DATA,CK_TAG,CK_DATA),
//   NIB_PER_WORD = DATA_W/4.
//  Sub-module mvt_out_fifo (reg-array FIFO, count, full_n, empty), instantiated twice.
// TESTING
//  x1 write 32'hDEADBEEF from idle -> 2 cycles later data_out 1,D,E,A,D,B,E,E,F, valid 9 cycles.
//  Same-cycle x1=32'h11111111, x2=32'h22222222 -> x1 frame then x2 frame, no gap (18 valid).
//  5 x1 writes back-to-back, DEPTH=4, no drain -> full_n low after 4th; 5th dropped, probe_out=1.
//  ap_rst=1 during nibble 3 of a frame -> next cycle data_valid=0, data_out=0, full_n=1, probe_out=0.
//  Continuous writes on both streams -> strict alternation x1,x2,x1,... with no lost words.
//  CKSUM_EN, WORDS_PER_STREAM=2, x1={1,2}, x2={4,8} -> after 4 frames, tag C + 32'h0000000F.

Source files
------------

// File: rtl/mvt_out_pkg.sv
// Shared constants and FSM state type for the mvt output serializer.
package mvt_out_pkg;

    localparam int NIB_PER_WORD = 8;

    localparam logic [3:0] TAG_X1 = 4'h1;
    localparam logic [3:0] TAG_X2 = 4'h2;
    localparam logic [3:0] TAG_CK = 4'hC;

    typedef enum logic [2:0] {
        IDLE,
        TAG,
        DATA,
        CK_TAG,
        CK_DATA
    } state_e;

endpackage

// File: rtl/mvt_out_fifo.sv
// Register-array FIFO buffering one kernel output stream; full_n and empty come from the registered count.
module mvt_out_fifo #(
    parameter int W     = 32,
    parameter int DEPTH = 4
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_wr,
    input  logic [W-1:0] i_wr_data,
    input  logic         i_rd,
    output logic [W-1:0] o_rd_data,
    output logic         o_full_n,
    output logic         o_empty
);

    localparam int AW = $clog2(DEPTH);

    logic [W-1:0]  r_mem [DEPTH];
    logic [AW-1:0] r_wr_ptr;
    logic [AW-1:0] r_rd_ptr;
    logic [AW:0]   r_count;
    logic          w_wr_ok;
    logic          w_rd_ok;

    // A pop on a full buffer frees its slot only from the next cycle on.
    assign o_full_n  = (r_count != (AW+1)'(DEPTH));
    assign o_empty   = (r_count == '0);
    assign o_rd_data = r_mem[r_rd_ptr];
    assign w_wr_ok   = i_wr & o_full_n;
    assign w_rd_ok   = i_rd & ~o_empty;

    // NOTE: sequential state is written only with non-blocking assignments so every flop samples pre-edge values.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wr_ptr <= '0;
            r_rd_ptr <= '0;
            r_count  <= '0;
        end else begin
            if (w_wr_ok) r_wr_ptr <= r_wr_ptr + AW'(1);
            if (w_rd_ok) r_rd_ptr <= r_rd_ptr + AW'(1);
            r_count <= r_count + {{AW{1'b0}}, w_wr_ok} - {{AW{1'b0}}, w_rd_ok};
        end
    end

    // NOTE: storage is not reset; the pointers and count alone decide which entries are valid.
    always_ff @(posedge i_clk) begin
        if (w_wr_ok) r_mem[r_wr_ptr] <= i_wr_data;
    end

endmodule

// File: rtl/mvt_out_serializer.sv
// Buffers the x1/x2 kernel streams, round-robin arbitrates and emits tagged nibble frames.
// Optional trailing checksum frame per run when MVT_OUT_CKSUM_EN is defined.
module mvt_out_serializer
    import mvt_out_pkg::*;
#(
    parameter int DATA_W           = NIB_PER_WORD * 4,
    parameter int FIFO_DEPTH       = 4,
    parameter int WORDS_PER_STREAM = 40
) (
    input  logic              ap_clk,
    input  logic              ap_rst,
    input  logic [DATA_W-1:0] x1_out_din,
    input  logic              x1_out_write,
    output logic              x1_out_full_n,
    input  logic [DATA_W-1:0] x2_out_din,
    input  logic              x2_out_write,
    output logic              x2_out_full_n,
    output logic [3:0]        data_out,
    output logic              data_valid,
    output logic              probe_out
);

    localparam int NIBS  = DATA_W / 4;
    localparam int CNT_W = (NIBS > 1) ? $clog2(NIBS) : 1;

    state_e            r_state;
    state_e            w_next_state;
    logic [DATA_W-1:0] r_shift;
    logic [3:0]        r_tag;
    logic [CNT_W-1:0]  r_nib_cnt;
    logic              r_rr_x2;
    logic [3:0]        r_data_out;
    logic              r_data_valid;
    logic              r_probe;

    logic [DATA_W-1:0] w_x1_word;
    logic [DATA_W-1:0] w_x2_word;
    logic              w_x1_empty;
    logic              w_x2_empty;
    logic              w_last;
    logic              w_decide;
    logic              w_sel_x2;
    logic              w_load;
    logic              w_ck_ready;
    logic              w_start_ck;
    logic [DATA_W-1:0] w_ck_word;
    logic [3:0]        w_nib;
    logic              w_nib_valid;

    mvt_out_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_x1 (
        .i_clk     (ap_clk),
        .i_rst     (ap_rst),
        .i_wr      (x1_out_write),
        .i_wr_data (x1_out_din),
        .i_rd      (w_load & ~w_sel_x2),
        .o_rd_data (w_x1_word),
        .o_full_n  (x1_out_full_n),
        .o_empty   (w_x1_empty)
    );

    mvt_out_fifo #(.W(DATA_W), .DEPTH(FIFO_DEPTH)) u_fifo_x2 (
        .i_clk     (ap_clk),
        .i_rst     (ap_rst),
        .i_wr      (x2_out_write),
        .i_wr_data (x2_out_din),
        .i_rd      (w_load & w_sel_x2),
        .o_rd_data (w_x2_word),
        .o_full_n  (x2_out_full_n),
        .o_empty   (w_x2_empty)
    );

    // A new frame may start from IDLE or on the last nibble of a frame, giving gap-free frames.
    assign w_last     = (r_nib_cnt == CNT_W'(NIBS - 1));
    assign w_decide   = (r_state == IDLE) || (((r_state == DATA) || (r_state == CK_DATA)) && w_last);
    assign w_sel_x2   = ~w_x2_empty & (w_x1_empty | r_rr_x2);
    assign w_load     = w_decide & ~(w_x1_empty & w_x2_empty);
    assign w_start_ck = w_decide & w_ck_ready;

`ifdef MVT_OUT_CKSUM_EN
    localparam int WC_W = $clog2(WORDS_PER_STREAM + 1);

    logic [WC_W-1:0]   r_cnt_x1;
    logic [WC_W-1:0]   r_cnt_x2;
    logic [DATA_W-1:0] r_xor_x1;
    logic [DATA_W-1:0] r_xor_x2;
    logic              w_acc_x1;
    logic              w_acc_x2;

    assign w_acc_x1   = x1_out_write & x1_out_full_n;
    assign w_acc_x2   = x2_out_write & x2_out_full_n;
    assign w_ck_ready = (r_cnt_x1 == WC_W'(WORDS_PER_STREAM)) && (r_cnt_x2 == WC_W'(WORDS_PER_STREAM))
                        && w_x1_empty && w_x2_empty;
    assign w_ck_word  = r_xor_x1 ^ r_xor_x2;

    // Starting the checksum opens the next run; a word accepted on that same edge belongs to it.
    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_cnt_x1 <= '0;
            r_cnt_x2 <= '0;
            r_xor_x1 <= '0;
            r_xor_x2 <= '0;
        end else if (w_start_ck) begin
            r_cnt_x1 <= WC_W'(w_acc_x1);
            r_cnt_x2 <= WC_W'(w_acc_x2);
            r_xor_x1 <= w_acc_x1 ? x1_out_din : '0;
            r_xor_x2 <= w_acc_x2 ? x2_out_din : '0;
        end else begin
            if (w_acc_x1 && (r_cnt_x1 != WC_W'(WORDS_PER_STREAM))) r_cnt_x1 <= r_cnt_x1 + 1'b1;
            if (w_acc_x2 && (r_cnt_x2 != WC_W'(WORDS_PER_STREAM))) r_cnt_x2 <= r_cnt_x2 + 1'b1;
            if (w_acc_x1) r_xor_x1 <= r_xor_x1 ^ x1_out_din;
            if (w_acc_x2) r_xor_x2 <= r_xor_x2 ^ x2_out_din;
        end
    end
`else
    assign w_ck_ready = 1'b0;
    assign w_ck_word  = '0;
`endif

    // NOTE: every output of this block gets a default first, so no path can infer a latch.
    always_comb begin
        w_next_state = r_state;
        w_nib        = 4'h0;
        w_nib_valid  = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_start_ck)  w_next_state = CK_TAG;
                else if (w_load) w_next_state = TAG;
            end
            TAG, CK_TAG: begin
                w_nib        = r_tag;
                w_nib_valid  = 1'b1;
                w_next_state = (r_state == TAG) ? DATA : CK_DATA;
            end
            DATA, CK_DATA: begin
                w_nib       = r_shift[DATA_W-1 -: 4];
                w_nib_valid = 1'b1;
                if (w_last) begin
                    if (w_start_ck)  w_next_state = CK_TAG;
                    else if (w_load) w_next_state = TAG;
                    else             w_next_state = IDLE;
                end
            end
            default: w_next_state = IDLE;
        endcase
    end

    always_ff @(posedge ap_clk) begin
        if (ap_rst) begin
            r_state      <= IDLE;
            r_shift      <= '0;
            r_tag        <= 4'h0;
            r_nib_cnt    <= '0;
            r_rr_x2      <= 1'b0;
            r_data_out   <= 4'h0;
            r_data_valid <= 1'b0;
            r_probe      <= 1'b0;
        end else begin
            r_state      <= w_next_state;
            r_data_out   <= w_nib;
            r_data_valid <= w_nib_valid;
            r_probe      <= r_probe | (x1_out_write & ~x1_out_full_n) | (x2_out_write & ~x2_out_full_n);
            if (w_load) begin
                r_shift   <= w_sel_x2 ? w_x2_word : w_x1_word;
                r_tag     <= w_sel_x2 ? TAG_X2 : TAG_X1;
                r_rr_x2   <= ~w_sel_x2;
                r_nib_cnt <= '0;
            end else if (w_start_ck) begin
                r_shift   <= w_ck_word;
                r_tag     <= TAG_CK;
                r_nib_cnt <= '0;
            end else if ((r_state == DATA) || (r_state == CK_DATA)) begin
                r_shift   <= r_shift << 4;
                r_nib_cnt <= w_last ? '0 : r_nib_cnt + 1'b1;
            end
        end
    end

    assign data_out   = r_data_out;
    assign data_valid = r_data_valid;
    assign probe_out  = r_probe;

endmodule

// File: tb/tb_mvt_out_serializer.sv
// Self-checking bench for mvt_out_serializer: frame monitor + per-stream scoreboard, vector table and corner sequences.
module tb_mvt_out_serializer;

    localparam int DATA_W = 32;
    localparam int DEPTH  = 4;
    localparam int NIBS   = DATA_W / 4;
`ifdef MVT_OUT_CKSUM_EN
    localparam int WPS = 2;
`else
    localparam int WPS = 40;
`endif

    logic              ap_clk = 1'b0;
    logic              ap_rst = 1'b1;
    logic [DATA_W-1:0] x1_out_din = '0;
    logic              x1_out_write = 1'b0;
    logic              x1_out_full_n;
    logic [DATA_W-1:0] x2_out_din = '0;
    logic              x2_out_write = 1'b0;
    logic              x2_out_full_n;
    logic [3:0]        data_out;
    logic              data_valid;
    logic              probe_out;

    mvt_out_serializer #(
        .DATA_W           (DATA_W),
        .FIFO_DEPTH       (DEPTH),
        .WORDS_PER_STREAM (WPS)
    ) dut (
        .ap_clk        (ap_clk),
        .ap_rst        (ap_rst),
        .x1_out_din    (x1_out_din),
        .x1_out_write  (x1_out_write),
        .x1_out_full_n (x1_out_full_n),
        .x2_out_din    (x2_out_din),
        .x2_out_write  (x2_out_write),
        .x2_out_full_n (x2_out_full_n),
        .data_out      (data_out),
        .data_valid    (data_valid),
        .probe_out     (probe_out)
    );

    always #5 ap_clk = ~ap_clk;

    int cyc = 0;
    always @(posedge ap_clk) cyc <= cyc + 1;

    int n_checks = 0;
    int n_errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic flag(input string name, input string msg);
        n_checks++;
        n_errors++;
        $display("FAIL %s: %s", name, msg);
    endtask

    // Scoreboard: words pushed when driven, popped when the matching frame completes.
    logic [31:0] exp_q1[$];
    logic [31:0] exp_q2[$];
    logic [31:0] ck_q[$];
    logic [3:0]  tag_log[$];
    int          start_log[$];
    int          frames_done = 0;
    int          nib_idx = 0;
    logic [3:0]  cur_tag;
    logic [31:0] cur_word;
    int          cur_start;
    int          cur_run = 0;
    int          last_run = 0;
    int          idle_nz = 0;

    task automatic frame_done();
        case (cur_tag)
            4'h1: begin
                if (exp_q1.size() > 0) check("x1_frame_word", cur_word, exp_q1.pop_front());
                else flag("x1_frame_unexpected", $sformatf("got word 0x%0h with nothing queued", cur_word));
            end
            4'h2: begin
                if (exp_q2.size() > 0) check("x2_frame_word", cur_word, exp_q2.pop_front());
                else flag("x2_frame_unexpected", $sformatf("got word 0x%0h with nothing queued", cur_word));
            end
`ifdef MVT_OUT_CKSUM_EN
            4'hC: ck_q.push_back(cur_word);
`endif
            default: flag("frame_tag", $sformatf("got tag 0x%0h, required 0x1 or 0x2", cur_tag));
        endcase
        if (cur_tag == 4'h1 || cur_tag == 4'h2) begin
            tag_log.push_back(cur_tag);
            start_log.push_back(cur_start);
            frames_done++;
        end
    endtask

    always @(negedge ap_clk) begin
        if (ap_rst) begin
            nib_idx = 0;
            cur_run = 0;
        end else if (data_valid) begin
            cur_run++;
            if (nib_idx == 0) begin
                cur_tag   = data_out;
                cur_word  = '0;
                cur_start = cyc;
            end else begin
                cur_word = {cur_word[27:0], data_out};
            end
            nib_idx++;
            if (nib_idx == NIBS + 1) begin
                nib_idx = 0;
                frame_done();
            end
        end else begin
            if (data_out !== 4'h0) idle_nz++;
            if (cur_run > 0) last_run = cur_run;
            cur_run = 0;
        end
    end

    task automatic clear_sb();
        exp_q1.delete();
        exp_q2.delete();
        ck_q.delete();
        tag_log.delete();
        start_log.delete();
        frames_done = 0;
        last_run    = 0;
    endtask

    task automatic do_reset();
        @(negedge ap_clk);
        ap_rst       = 1'b1;
        x1_out_write = 1'b0;
        x2_out_write = 1'b0;
        repeat (2) @(negedge ap_clk);
        ap_rst = 1'b0;
        clear_sb();
    endtask

    task automatic write_pair(input logic w1, input logic w2, input logic [31:0] d1,
                              input logic [31:0] d2, output int wcyc);
        @(negedge ap_clk);
        x1_out_write = w1;
        x2_out_write = w2;
        x1_out_din   = d1;
        x2_out_din   = d2;
        if (w1) exp_q1.push_back(d1);
        if (w2) exp_q2.push_back(d2);
        @(negedge ap_clk);
        wcyc         = cyc;
        x1_out_write = 1'b0;
        x2_out_write = 1'b0;
    endtask

    task automatic wait_frames(input int n, input int budget, input string name);
        for (int i = 0; i < budget && frames_done < n; i++) @(posedge ap_clk);
        if (frames_done < n) flag(name, $sformatf("timeout with %0d frames, required %0d", frames_done, n));
    endtask

    // Six back-to-back x1 writes; the first word is popped one edge after it lands, so the
    // buffer fills on the fifth write and the sixth is dropped.
    logic fn[6];
    logic pr[6];
    task automatic burst_x1();
        for (int i = 0; i < 6; i++) begin
            @(negedge ap_clk);
            if (i > 0) begin
                fn[i-1] = x1_out_full_n;
                pr[i-1] = probe_out;
            end
            x1_out_write = 1'b1;
            x1_out_din   = 32'hA000_0000 + i;
            if (i < 5) exp_q1.push_back(x1_out_din);
        end
        @(negedge ap_clk);
        fn[5]        = x1_out_full_n;
        pr[5]        = probe_out;
        x1_out_write = 1'b0;
    endtask

    task automatic feed(input logic sel_x2, input int n);
        int i = 0;
        for (int t = 0; t < 400 && i < n; t++) begin
            @(negedge ap_clk);
            if (!sel_x2) begin
                x1_out_write = x1_out_full_n;
                if (x1_out_full_n) begin
                    x1_out_din = 32'h1000_0000 + i;
                    exp_q1.push_back(x1_out_din);
                    i++;
                end
            end else begin
                x2_out_write = x2_out_full_n;
                if (x2_out_full_n) begin
                    x2_out_din = 32'h2000_0000 + i;
                    exp_q2.push_back(x2_out_din);
                    i++;
                end
            end
        end
        @(negedge ap_clk);
        if (!sel_x2) x1_out_write = 1'b0;
        else         x2_out_write = 1'b0;
        if (i < n) flag("feed_timeout", $sformatf("stream %0d wrote %0d of %0d words", sel_x2 + 1, i, n));
    endtask

    typedef struct {
        logic        w1;
        logic        w2;
        logic [31:0] d1;
        logic [31:0] d2;
        logic [3:0]  first_tag;
        int          n_frames;
        int          run;
    } vec_t;

    vec_t        vecs[5];
    int          wcyc;
    logic [5:0]  fn_exp;
    logic [5:0]  pr_exp;

    initial begin
        vecs[0] = '{1'b1, 1'b0, 32'hDEADBEEF, 32'h0,        4'h1, 1, 9};
        vecs[1] = '{1'b0, 1'b1, 32'h0,        32'hCAFEF00D, 4'h2, 1, 9};
        vecs[2] = '{1'b1, 1'b1, 32'h11111111, 32'h22222222, 4'h1, 2, 18};
        vecs[3] = '{1'b1, 1'b0, 32'h00000000, 32'h0,        4'h1, 1, 9};
        vecs[4] = '{1'b0, 1'b1, 32'h0,        32'hFFFFFFFF, 4'h2, 1, 9};
        fn_exp  = 6'b001111;
        pr_exp  = 6'b100000;

        // Reset state
        do_reset();
        check("rst_data_valid", data_valid, 0);
        check("rst_data_out", data_out, 0);
        check("rst_x1_full_n", x1_out_full_n, 1);
        check("rst_x2_full_n", x2_out_full_n, 1);
        check("rst_probe", probe_out, 0);

        // Single-shot vectors from idle
        for (int v = 0; v < 5; v++) begin
            do_reset();
            write_pair(vecs[v].w1, vecs[v].w2, vecs[v].d1, vecs[v].d2, wcyc);
            wait_frames(vecs[v].n_frames, 60, $sformatf("vec%0d_frames", v));
            repeat (3) @(negedge ap_clk);
            check($sformatf("vec%0d_nframes", v), frames_done, vecs[v].n_frames);
            check($sformatf("vec%0d_valid_run", v), last_run, vecs[v].run);
            check($sformatf("vec%0d_sb_left", v), exp_q1.size() + exp_q2.size(), 0);
            if (start_log.size() > 0) begin
                check($sformatf("vec%0d_latency", v), start_log[0] - wcyc, 2);
                check($sformatf("vec%0d_first_tag", v), tag_log[0], vecs[v].first_tag);
            end
        end

        // Overflow: full_n drops, extra write dropped, probe sticky
        do_reset();
        burst_x1();
        for (int i = 0; i < 6; i++) begin
            check($sformatf("ovf_full_n_after_w%0d", i), fn[i], fn_exp[i]);
            check($sformatf("ovf_probe_after_w%0d", i), pr[i], pr_exp[i]);
        end
        wait_frames(5, 80, "ovf_frames");
        repeat (3) @(negedge ap_clk);
        check("ovf_nframes", frames_done, 5);
        check("ovf_sb_left", exp_q1.size(), 0);
        check("ovf_probe_sticky", probe_out, 1);
        check("ovf_full_n_drained", x1_out_full_n, 1);

        // Reset in the middle of a frame with words still buffered
        do_reset();
        burst_x1();
        for (int k = 0; k < 60 && !(frames_done >= 1 && nib_idx == 3); k++) @(posedge ap_clk);
        if (!(frames_done >= 1 && nib_idx == 3)) flag("midrst_wait", "second frame never reached nibble 3");
        @(negedge ap_clk);
        ap_rst = 1'b1;
        @(negedge ap_clk);
        check("midrst_data_valid", data_valid, 0);
        check("midrst_data_out", data_out, 0);
        check("midrst_x1_full_n", x1_out_full_n, 1);
        check("midrst_x2_full_n", x2_out_full_n, 1);
        check("midrst_probe", probe_out, 0);
        ap_rst = 1'b0;
        clear_sb();
        repeat (30) @(negedge ap_clk);
        check("midrst_discarded", frames_done, 0);

        // Continuous writes on both streams: strict alternation, nothing lost
        do_reset();
        fork
            feed(1'b0, 6);
            feed(1'b1, 6);
        join
        wait_frames(12, 300, "alt_frames");
        repeat (3) @(negedge ap_clk);
        check("alt_nframes", frames_done, 12);
        check("alt_sb_left", exp_q1.size() + exp_q2.size(), 0);
        check("alt_probe", probe_out, 0);
        if (tag_log.size() > 0) check("alt_first_tag", tag_log[0], 4'h1);
        for (int i = 1; i < tag_log.size(); i++)
            check($sformatf("alt_order%0d", i), tag_log[i], (tag_log[i-1] == 4'h1) ? 4'h2 : 4'h1);

`ifdef MVT_OUT_CKSUM_EN
        // Checksum frame after a full run of two words per stream
        do_reset();
        write_pair(1'b1, 1'b1, 32'h1, 32'h4, wcyc);
        write_pair(1'b1, 1'b1, 32'h2, 32'h8, wcyc);
        wait_frames(4, 100, "ck_data_frames");
        for (int k = 0; k < 40 && ck_q.size() == 0; k++) @(posedge ap_clk);
        repeat (3) @(negedge ap_clk);
        check("ck_nframes", ck_q.size(), 1);
        if (ck_q.size() > 0) check("ck_word", ck_q[0], 32'h0000000F);
        check("ck_valid_run", last_run, 45);
        if (tag_log.size() == 4) begin
            check("ck_order0", tag_log[0], 4'h1);
            check("ck_order1", tag_log[1], 4'h2);
            check("ck_order2", tag_log[2], 4'h1);
            check("ck_order3", tag_log[3], 4'h2);
        end else begin
            flag("ck_order", $sformatf("got %0d data frames, required 4", tag_log.size()));
        end
`endif

        check("idle_data_out_zero", idle_nz, 0);
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation did not finish within time limit");
        $fatal(1, "watchdog expired");
    end

endmodule
